conv_acc_unit: RTL and testbench

CONV_ACC_UNIT -- requirements
Module: conv_acc_unit

---
 rtl/conv_pkg.sv | 43 ++++
 rtl/conv_acc_unit_if.sv | 43 ++++
 rtl/conv_requant.sv | 34 +++
 rtl/conv_acc_unit.sv | 168 ++++++++++++++++
 tb/tb_conv_acc_unit.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared defaults, per-beat tag type and signed-saturation
//                helper for the convolution accumulate unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int DEF_K_H            = 3;
  localparam int DEF_K_W            = 3;
  localparam int DEF_IN_DATA_WIDTH  = 9;
  localparam int DEF_W_WIDTH        = 8;
  localparam int DEF_C_IN           = 4;
  localparam int DEF_ACC_WIDTH      = 24;
  localparam int DEF_OUT_DATA_WIDTH = 8;

  // Side information that rides along with each beat through the pipeline.
  typedef struct packed {
    logic       is_first;
    logic       is_last;
    logic       relu;
    logic [4:0] shift;
  } beat_tag_t;

  // Clamp a wide signed value to the signed range of WIDTH bits.
  // The caller truncates the result down to WIDTH bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_acc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_acc_unit_if
//  Description : Beat input / result output handshake bundle of the
//                convolution accumulate unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_acc_unit_if
  import conv_pkg::*;
#(
  parameter int K_H            = DEF_K_H,
  parameter int K_W            = DEF_K_W,
  parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
  parameter int W_WIDTH        = DEF_W_WIDTH,
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH
);

  logic                                in_valid;
  logic                                in_ready;
  logic [K_H*K_W*IN_DATA_WIDTH-1:0]    conv_win;
  logic [K_H*K_W*W_WIDTH-1:0]          w;
  logic                                en_relu;
  logic [4:0]                          shift;
  logic                                out_valid;
  logic                                out_ready;
  logic [OUT_DATA_WIDTH-1:0]           out_pixel;
  logic [ACC_WIDTH-1:0]                out_acc;

  // Accumulator side.
  modport slave (
    input  in_valid, conv_win, w, en_relu, shift, out_ready,
    output in_ready, out_valid, out_pixel, out_acc
  );

  // Producer / consumer side.
  modport master (
    output in_valid, conv_win, w, en_relu, shift, out_ready,
    input  in_ready, out_valid, out_pixel, out_acc
  );

endinterface
`default_nettype wire

// File: rtl/conv_requant.sv
`default_nettype none
// ============================================================================
//  Module      : conv_requant
//  Description : Optional ReLU, arithmetic right shift and saturation of an
//                accumulator value down to the output pixel width.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_requant
  import conv_pkg::*;
#(
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]      acc_i,
  input  logic                             en_relu_i,
  input  logic [4:0]                       shift_i,
  output logic signed [OUT_DATA_WIDTH-1:0] pixel_o
);

  logic signed [ACC_WIDTH-1:0] w_relu;
  logic signed [ACC_WIDTH-1:0] w_shift;

  // ReLU, then floor-shift, then clamp into the output range.
  always_comb begin
    w_relu = acc_i;
    if (en_relu_i && acc_i[ACC_WIDTH-1]) begin
      w_relu = '0;
    end
    w_shift = w_relu >>> shift_i;
    pixel_o = OUT_DATA_WIDTH'(sat_signed(64'(w_shift), OUT_DATA_WIDTH));
  end

endmodule
`default_nettype wire

// File: rtl/conv_acc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : conv_acc_unit
//  Description : 3-stage multiply / sum / accumulate pipeline that folds C_IN
//                channel beats into one requantized output pixel.
//                Build option CONV_ACC_SAT_EN: saturate the accumulator to the
//                ACC_WIDTH signed range instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_acc_unit
  import conv_pkg::*;
#(
  parameter int K_H            = DEF_K_H,
  parameter int K_W            = DEF_K_W,
  parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
  parameter int W_WIDTH        = DEF_W_WIDTH,
  parameter int C_IN           = DEF_C_IN,
  parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
  parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  conv_acc_unit_if.slave bus
);

  localparam int NTAPS  = K_H * K_W;
  localparam int PROD_W = IN_DATA_WIDTH + W_WIDTH;
  localparam int SUM_W  = PROD_W + $clog2(NTAPS);
  localparam int CNT_W  = (C_IN > 1) ? $clog2(C_IN) : 1;

  logic                              w_stall;
  logic                              w_adv;
  logic                              w_accept;
  logic                              w_first;
  logic                              w_last;
  beat_tag_t                         w_tag;
  logic [CNT_W-1:0]                  cnt_q;
  logic [CNT_W-1:0]                  cnt_d;

  logic signed [PROD_W-1:0]          w_prod [NTAPS];
  logic signed [PROD_W-1:0]          p_prod_q [NTAPS];
  logic                              p_valid_q;
  beat_tag_t                         p_tag_q;

  logic signed [SUM_W-1:0]           w_sum;
  logic signed [SUM_W-1:0]           s_sum_q;
  logic                              s_valid_q;
  beat_tag_t                         s_tag_q;

  logic signed [ACC_WIDTH-1:0]       acc_q;
  logic signed [ACC_WIDTH-1:0]       acc_d;
  logic signed [63:0]                w_sum_ext;
  logic signed [63:0]                w_acc_ext;
  logic signed [OUT_DATA_WIDTH-1:0]  w_pixel;
  logic                              out_valid_q;
  logic [ACC_WIDTH-1:0]              out_acc_q;
  logic [OUT_DATA_WIDTH-1:0]         out_pixel_q;

  // A held, unconsumed result freezes the whole pipeline.
  assign w_stall  = out_valid_q && !bus.out_ready;
  assign w_adv    = !w_stall;
  assign w_accept = bus.in_valid && w_adv;
  assign w_first  = (cnt_q == '0);
  assign w_last   = (cnt_q == CNT_W'(C_IN - 1));

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_pixel = out_pixel_q;

  // One signed multiplier per window tap.
  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_prod
    logic signed [IN_DATA_WIDTH-1:0] w_pix;
    logic signed [W_WIDTH-1:0]       w_wt;
    assign w_pix       = bus.conv_win[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH];
    assign w_wt        = bus.w[gi*W_WIDTH +: W_WIDTH];
    assign w_prod[gi]  = PROD_W'(w_pix) * PROD_W'(w_wt);
  end

  // Channel counter next state and the tag attached to the incoming beat.
  always_comb begin
    cnt_d = cnt_q;
    if (w_accept) begin
      cnt_d = w_last ? '0 : cnt_q + CNT_W'(1);
    end
    w_tag = '{is_first: w_first, is_last: w_last,
              relu: bus.en_relu, shift: bus.shift};
  end

  // Full-precision adder tree over the registered products.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NTAPS; i++) begin
      w_sum = w_sum + SUM_W'(p_prod_q[i]);
    end
  end

  // Accumulate: first beat loads, later beats add; saturate or wrap.
  always_comb begin
    w_sum_ext = 64'(s_sum_q);
    w_acc_ext = 64'(acc_q);
`ifdef CONV_ACC_SAT_EN
    acc_d = ACC_WIDTH'(sat_signed(s_tag_q.is_first ? w_sum_ext
                                                   : w_acc_ext + w_sum_ext,
                                  ACC_WIDTH));
`else
    acc_d = ACC_WIDTH'(s_tag_q.is_first ? w_sum_ext : w_acc_ext + w_sum_ext);
`endif
  end

  conv_requant #(
    .ACC_WIDTH      (ACC_WIDTH),
    .OUT_DATA_WIDTH (OUT_DATA_WIDTH)
  ) u_requant (
    .acc_i     (acc_d),
    .en_relu_i (s_tag_q.relu),
    .shift_i   (s_tag_q.shift),
    .pixel_o   (w_pixel)
  );

  // Control state: counter and stage valids, all frozen on a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      p_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else if (w_adv) begin
      cnt_q     <= cnt_d;
      p_valid_q <= w_accept;
      s_valid_q <= p_valid_q;
    end
  end

  // Datapath stage registers P and S; qualified by the valids above.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int i = 0; i < NTAPS; i++) begin
        p_prod_q[i] <= w_prod[i];
      end
      p_tag_q <= w_tag;
      s_sum_q <= w_sum;
      s_tag_q <= p_tag_q;
    end
  end

  // Stage O: accumulator and the output result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_pixel_q <= '0;
    end else if (w_adv) begin
      if (s_valid_q) begin
        acc_q <= acc_d;
      end
      if (s_valid_q && s_tag_q.is_last) begin
        out_valid_q <= 1'b1;
        out_acc_q   <= acc_d;
        out_pixel_q <= w_pixel;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_acc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_acc_unit
//  Description : Self-checking bench for conv_acc_unit (3x3, C_IN=4) plus a
//                16-bit accumulator instance for overflow behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_acc_unit;

  localparam int KH = 3, KW = 3, IW = 9, WW = 8, CIN = 4, AW = 24, OW = 8;
  localparam int NT = KH * KW;
`ifdef CONV_ACC_SAT_EN
  localparam longint EXP16_ACC = 32767;
  localparam longint EXP16_PIX = 127;
  localparam bit     SAT       = 1'b1;
`else
  localparam longint EXP16_ACC = -29536;
  localparam longint EXP16_PIX = -128;
  localparam bit     SAT       = 1'b0;
`endif

  logic clk;
  logic rst;

  conv_acc_unit_if #(.K_H(KH), .K_W(KW), .IN_DATA_WIDTH(IW), .W_WIDTH(WW),
                     .ACC_WIDTH(AW), .OUT_DATA_WIDTH(OW)) bus ();
  conv_acc_unit_if #(.K_H(KH), .K_W(KW), .IN_DATA_WIDTH(IW), .W_WIDTH(WW),
                     .ACC_WIDTH(16), .OUT_DATA_WIDTH(OW)) bus16 ();

  conv_acc_unit #(.K_H(KH), .K_W(KW), .IN_DATA_WIDTH(IW), .W_WIDTH(WW),
                  .C_IN(CIN), .ACC_WIDTH(AW), .OUT_DATA_WIDTH(OW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  conv_acc_unit #(.K_H(KH), .K_W(KW), .IN_DATA_WIDTH(IW), .W_WIDTH(WW),
                  .C_IN(CIN), .ACC_WIDTH(16), .OUT_DATA_WIDTH(OW))
    dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int     ncmp = 0;
  int     nerr = 0;
  longint exp_acc[$];
  longint exp_pix[$];
  longint got_acc[$];
  longint got_pix[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint expv);
    ncmp++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: a uniform window of pixel PIX and weight WT repeated over all
  // channels; each beat contributes NT*PIX*WT.
  task automatic model(input int pix, input int wt, input bit relu,
                       input int sh, input int accw,
                       output longint acc, output longint pixo);
    longint m, mx, mn, s, r;
    m  = 64'sd1 <<< accw;
    mx = (m >>> 1) - 1;
    mn = -mx - 1;
    acc = 0;
    for (int c = 0; c < CIN; c++) begin
      s   = longint'(NT) * pix * wt;
      acc = (c == 0) ? s : acc + s;
      if (SAT) begin
        if (acc > mx) acc = mx;
        if (acc < mn) acc = mn;
      end else begin
        acc = acc % m;
        if (acc > mx) acc -= m;
        if (acc < mn) acc += m;
      end
    end
    r = (relu && acc < 0) ? 0 : acc;
    r = r >>> sh;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    pixo = r;
  endtask

  // Present one beat (called at a falling edge) until it is accepted.
  // Returns at the falling edge after acceptance with in_valid still high.
  task automatic beat(input int pix, input int wt, input bit relu, input int sh);
    logic [NT*IW-1:0] wv;
    logic [NT*WW-1:0] ww;
    bit               ok;
    int               tries;
    for (int i = 0; i < NT; i++) begin
      wv[i*IW +: IW] = IW'(pix);
      ww[i*WW +: WW] = WW'(wt);
    end
    bus.conv_win = wv;
    bus.w        = ww;
    bus.en_relu  = relu;
    bus.shift    = 5'(sh);
    bus.in_valid = 1'b1;
    ok    = 1'b0;
    tries = 0;
    while (!ok && tries < 200) begin
      #4;
      ok = bus.in_ready;
      @(posedge clk);
      @(negedge clk);
      tries++;
    end
    if (!ok) begin
      ncmp++;
      nerr++;
      $display("FAIL beat_accept_timeout: got in_ready 0 for %0d cycles, expected 1", tries);
    end
  endtask

  task automatic send_window(input int pix, input int wt, input bit relu, input int sh);
    longint a, p;
    for (int c = 0; c < CIN; c++) begin
      beat(pix, wt, relu, sh);
    end
    model(pix, wt, relu, sh, AW, a, p);
    exp_acc.push_back(a);
    exp_pix.push_back(p);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_acc.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      ncmp++;
      nerr++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_acc.size());
    end
  endtask

  // Per-cycle compare of the main instance against the reference queue.
  initial begin : compare
    bit     prev_stall;
    longint prev_acc, prev_pix, a, p;
    prev_stall = 1'b0;
    prev_acc   = 0;
    prev_pix   = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        a = longint'($signed(bus.out_acc));
        p = longint'($signed(bus.out_pixel));
        chk("in_ready_rule", longint'(bus.in_ready),
            longint'(!(bus.out_valid && !bus.out_ready)));
        if (prev_stall) begin
          chk("stall_out_valid", longint'(bus.out_valid), 1);
          chk("stall_acc_stable", a, prev_acc);
          chk("stall_pix_stable", p, prev_pix);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_acc.size() == 0) begin
            ncmp++;
            nerr++;
            $display("FAIL spurious_out_valid: got out_acc %0d, expected no result", a);
          end else begin
            chk("out_acc", a, exp_acc.pop_front());
            chk("out_pixel", p, exp_pix.pop_front());
            got_acc.push_back(a);
            got_pix.push_back(p);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_acc   = a;
        prev_pix   = p;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin : main
    longint ma, mp;
    int     lat;
    bit     found;

    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.conv_win = '0; bus.w = '0;
    bus.en_relu  = 1'b0;  bus.shift = '0;    bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.conv_win = '0; bus16.w = '0;
    bus16.en_relu  = 1'b0; bus16.shift = '0;    bus16.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Pin the reference model on hand-computed values.
    model(1, 1, 0, 0, AW, ma, mp);     chk("model_ones_acc", ma, 36);
    model(255, 127, 0, 0, AW, ma, mp); chk("model_big_acc", ma, 1165860);
    model(50, 20, 0, 0, 16, ma, mp);   chk("model_acc16", ma, EXP16_ACC);

    // Reset state.
    #1;
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_acc",   longint'(bus.out_acc), 0);
    chk("rst_out_pixel", longint'(bus.out_pixel), 0);
    chk("rst_in_ready",  longint'(bus.in_ready), 1);
    @(negedge clk);

    // 16-bit accumulator overflow: wrap or saturate.
    for (int i = 0; i < NT; i++) begin
      bus16.conv_win[i*IW +: IW] = IW'(50);
      bus16.w[i*WW +: WW]        = WW'(20);
    end
    bus16.in_valid = 1'b1;
    for (int b = 0; b < CIN; b++) begin
      #4;
      chk("acc16_in_ready", longint'(bus16.in_ready), 1);
      @(posedge clk);
      @(negedge clk);
    end
    bus16.in_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      #2;
      if (bus16.out_valid) found = 1'b1;
      else @(negedge clk);
    end
    chk("acc16_valid_seen", longint'(found), 1);
    chk("acc16_out_acc", longint'($signed(bus16.out_acc)), EXP16_ACC);
    chk("acc16_out_pixel", longint'($signed(bus16.out_pixel)), EXP16_PIX);
    @(negedge clk);

    // Ones window with latency measurement.
    send_window(1, 1, 1'b0, 0);
    bus.in_valid = 1'b0;
    lat   = 0;
    found = 1'b0;
    for (int k = 1; k <= 8 && !found; k++) begin
      #3;
      if (bus.out_valid) begin
        found = 1'b1;
        lat   = k;
      end else begin
        @(negedge clk);
      end
    end
    chk("latency_cycles", lat, 3);
    @(negedge clk);
    drain();
    chk("ones_acc", got_acc[$], 36);
    chk("ones_pix", got_pix[$], 36);

    // Negative values with and without ReLU.
    send_window(-1, 1, 1'b1, 0);
    send_window(-1, 1, 1'b0, 0);
    bus.in_valid = 1'b0;
    drain();
    chk("neg_relu_acc", got_acc[$-1], -36);
    chk("neg_relu_pix", got_pix[$-1], 0);
    chk("neg_norelu_pix", got_pix[$], -36);

    // Output saturation and shift.
    send_window(255, 127, 1'b0, 0);
    send_window(-256, 127, 1'b0, 0);
    send_window(1, 1, 1'b0, 2);
    bus.in_valid = 1'b0;
    drain();
    chk("big_acc", got_acc[$-2], 1165860);
    chk("big_pix", got_pix[$-2], 127);
    chk("small_pix", got_pix[$-1], -128);
    chk("shift2_pix", got_pix[$], 9);

    // Back-to-back windows with a 5-cycle output stall.
    fork
      begin
        send_window(1, 1, 1'b0, 0);
        send_window(2, 1, 1'b0, 0);
        bus.in_valid = 1'b0;
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
          @(negedge clk);
          #1;
          if (bus.out_valid) seen = 1'b1;
        end
        chk("stall_first_valid", longint'(seen), 1);
        bus.out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          #2;
          chk("stall_in_ready_low", longint'(bus.in_ready), 0);
          @(negedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("b2b_first_acc", got_acc[$-1], 36);
    chk("b2b_second_acc", got_acc[$], 72);

    // Reset in the middle of a window.
    beat(5, 1, 1'b0, 0);
    beat(5, 1, 1'b0, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst_in_ready", longint'(bus.in_ready), 1);
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    @(negedge clk);
    send_window(2, 1, 1'b0, 0);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    drain();
    chk("midrst_acc", got_acc[$], 72);
    chk("final_queue_empty", exp_acc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
